// File: rtl/trng_pkg.sv
// trng_pkg: default parameters and counter widths for the TRNG health-test stage.
package trng_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_RCT_CUTOFF = 5;
  localparam int DEF_APT_WINDOW = 512;
  localparam int DEF_APT_CUTOFF = 20;
  localparam int DEF_STARTUP_SAMPLES = 1024;
  localparam int RCT_W = 8;
  localparam int CNT_W = 16;
endpackage

// File: rtl/trng_apt_counter.sv
// trng_apt_counter: adaptive-proportion window tracker; pulses fail on the sample whose
// match count of the window reference reaches the cutoff.
module trng_apt_counter
  import trng_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             sample,
  input  logic [WIDTH-1:0] dat,
  input  logic             clear,
  output logic             fail
);
  logic [WIDTH-1:0] ref_dat;
  logic [CNT_W-1:0] match_cnt, win;
  logic open_win, hit;
  // win==0 is idle, win==APT_WINDOW is a closed window; either way the next sample opens one
  assign open_win = (win == '0) || (win == CNT_W'(APT_WINDOW));
  assign hit = !open_win && dat == ref_dat;
  assign fail = sample && hit && match_cnt + CNT_W'(1) == CNT_W'(APT_CUTOFF);
  always_ff @(posedge i_clk)
    if (i_reset || clear) begin
      win <= '0;
      match_cnt <= '0;
      ref_dat <= '0;
    end else if (sample) begin
      ref_dat <= open_win ? dat : ref_dat;
      win <= open_win ? CNT_W'(1) : win + CNT_W'(1);
      match_cnt <= open_win ? CNT_W'(1) : match_cnt + CNT_W'(hit);
    end
endmodule

// File: rtl/trng_health_mon.sv
// trng_health_mon: RCT/APT online health tests with startup gating and sticky alarms
// between the entropy byte source and the serial sender.
module trng_health_mon
  import trng_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF,
  parameter int STARTUP_SAMPLES = DEF_STARTUP_SAMPLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_valid,
  output logic             o_read,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_clear_alarm,
  output logic             o_alarm_rct,
  output logic             o_alarm_apt,
  output logic             o_startup_done
);
  logic acc, rct_hit, apt_hit, hit, alarm, first;
  logic [WIDTH-1:0] last;
  logic [RCT_W-1:0] rep, rep_nx;
  logic [CNT_W-1:0] scnt;
  assign o_read = (~o_valid | i_ready) & ~i_clear_alarm;
  assign acc = i_valid & o_read;
  assign rep_nx = (!first && i_dat == last) ? (rep == '1 ? rep : rep + RCT_W'(1)) : RCT_W'(1);
  assign rct_hit = acc && rep_nx == RCT_W'(RCT_CUTOFF);
  assign hit = rct_hit | apt_hit;
  assign alarm = o_alarm_rct | o_alarm_apt;
  trng_apt_counter #(
    .WIDTH(WIDTH),
    .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF)
  ) u_apt (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .sample(acc),
    .dat(i_dat),
    .clear(i_clear_alarm),
    .fail(apt_hit)
  );
  // a sample that raises an alarm is never forwarded and flushes the pending byte
  always_ff @(posedge i_clk)
    if (i_reset || i_clear_alarm) begin
      first <= 1'b1;
      last <= '0;
      rep <= '0;
      scnt <= '0;
      o_alarm_rct <= 1'b0;
      o_alarm_apt <= 1'b0;
      o_startup_done <= 1'b0;
      o_valid <= 1'b0;
      o_dat <= i_reset ? '0 : o_dat;
    end else begin
      if (acc) begin
        first <= 1'b0;
        last <= i_dat;
        rep <= rep_nx;
      end
      if (acc && scnt != CNT_W'(STARTUP_SAMPLES)) scnt <= scnt + CNT_W'(1);
      if (acc && !o_startup_done && !alarm && !hit && scnt + CNT_W'(1) == CNT_W'(STARTUP_SAMPLES))
        o_startup_done <= 1'b1;
      o_alarm_rct <= o_alarm_rct | rct_hit;
      o_alarm_apt <= o_alarm_apt | apt_hit;
      if (hit) o_valid <= 1'b0;
      else if (acc && o_startup_done && !alarm) begin
        o_valid <= 1'b1;
        o_dat <= i_dat;
      end else if (i_ready) o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_trng_health_mon.sv
// tb_trng_health_mon: randomized and directed checks of trng_health_mon against a
// history-based reference model of the health tests.
module tb_trng_health_mon;
  localparam int SU = 16, RCT = 4, APTW = 16, APTC = 6;
  logic clk = 0, rst = 0, valid = 0, ready = 1, clr = 0;
  logic [7:0] dat = 0;
  logic o_read, o_valid, o_alarm_rct, o_alarm_apt, o_startup_done;
  logic [7:0] o_dat;
  logic m_rd = 0, m_valid = 0, m_rct = 0, m_apt = 0, m_done = 0, obs_read = 0;
  logic [7:0] m_dat = 0;
  logic [7:0] hist[$];
  logic [12:0] obs_vec, exp_vec;
  int vec = 0, miss = 0;

  assign obs_vec = {obs_read, o_valid, o_dat, o_alarm_rct, o_alarm_apt, o_startup_done};
  assign exp_vec = {m_rd, m_valid, m_dat, m_rct, m_apt, m_done};

  always #5 clk = ~clk;

  trng_health_mon #(
    .WIDTH(8), .RCT_CUTOFF(RCT), .APT_WINDOW(APTW), .APT_CUTOFF(APTC), .STARTUP_SAMPLES(SU)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_dat(dat), .i_valid(valid), .o_read(o_read),
    .o_dat(o_dat), .o_valid(o_valid), .i_ready(ready), .i_clear_alarm(clr),
    .o_alarm_rct(o_alarm_rct), .o_alarm_apt(o_alarm_apt), .o_startup_done(o_startup_done)
  );

  // Reference model: keeps every sample tested since reset/clear and derives the run
  // length and the current APT window contents from that history.
  task automatic tick();
    logic rdm, acc, rh, ah, ld;
    int n, run, pos, st, cnt;
    #2;
    obs_read = o_read;
    rdm = (!m_valid || ready) && !clr;
    m_rd = rdm;
    if (rst) begin
      m_valid = 0; m_dat = 0; m_rct = 0; m_apt = 0; m_done = 0;
      hist.delete();
    end else if (clr) begin
      m_valid = 0; m_rct = 0; m_apt = 0; m_done = 0;
      hist.delete();
    end else begin
      acc = valid && rdm;
      rh = 0; ah = 0; n = 0;
      if (acc) begin
        hist.push_back(dat);
        n = hist.size();
        run = 0;
        for (int i = n - 1; i >= 0 && hist[i] == dat; i--) run++;
        rh = ((run > 255) ? 255 : run) == RCT;
        pos = (n - 1) % APTW;
        st = n - 1 - pos;
        cnt = 0;
        for (int i = st; i < n; i++) if (hist[i] == hist[st]) cnt++;
        ah = cnt == APTC;
      end
      ld = acc && m_done && !m_rct && !m_apt && !rh && !ah;
      if (acc && !m_done && !m_rct && !m_apt && !rh && !ah && n == SU) m_done = 1;
      if (rh || ah) m_valid = 0;
      else if (ld) begin m_valid = 1; m_dat = dat; end
      else if (ready) m_valid = 0;
      m_rct |= rh;
      m_apt |= ah;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; valid = 0; ready = 1;
    tick();
    rst = 0;
    vec++;
    if ({o_valid, o_alarm_rct, o_alarm_apt, o_startup_done} !== 4'b0 || o_dat !== 8'h00) begin
      miss++;
      $display("FAIL reset: got v/rct/apt/done=%b%b%b%b dat=%h required 0000 dat=00", o_valid, o_alarm_rct, o_alarm_apt, o_startup_done, o_dat);
    end
    #2;
    vec++;
    if (o_read !== 1'b1) begin miss++; $display("FAIL reset_read: got %b required 1", o_read); end
  endtask

  task automatic test_startup();
    for (int k = 0; k < 48; k++) begin
      dat = 8'(k); valid = 1;
      tick();
      vec++;
      if (obs_vec !== exp_vec) begin miss++; $display("FAIL startup[%0d]: got %h required %h", k, obs_vec, exp_vec); end
      vec++;
      if (o_startup_done !== (k >= 15) || (k >= 16 && (o_valid !== 1'b1 || o_dat !== 8'(k))) || (k < 16 && o_valid !== 1'b0)) begin
        miss++;
        $display("FAIL startup_fwd[%0d]: got done=%b v=%b dat=%h required done=%b dat=%h", k, o_startup_done, o_valid, o_dat, k >= 15, 8'(k));
      end
    end
  endtask

  task automatic test_rct();
    logic [7:0] seq [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h11, 8'hA5};
    for (int i = 0; i < 6; i++) begin
      dat = seq[i]; valid = 1;
      tick();
      vec++;
      if (obs_vec !== exp_vec) begin miss++; $display("FAIL rct[%0d]: got %h required %h", i, obs_vec, exp_vec); end
      vec++;
      if (i < 3 && (o_valid !== 1'b1 || o_dat !== 8'hA5 || o_alarm_rct !== 1'b0)) begin
        miss++; $display("FAIL rct_fwd[%0d]: got v=%b dat=%h rct=%b required 1/a5/0", i, o_valid, o_dat, o_alarm_rct);
      end else if (i >= 3 && (o_valid !== 1'b0 || o_alarm_rct !== 1'b1 || obs_read !== 1'b1)) begin
        miss++; $display("FAIL rct_alarm[%0d]: got v=%b rct=%b rd=%b required 0/1/1", i, o_valid, o_alarm_rct, obs_read);
      end
    end
  endtask

  task automatic test_clear();
    dat = 8'hA5; valid = 1; clr = 1;
    tick();
    clr = 0;
    vec++;
    if ({obs_read, o_valid, o_alarm_rct, o_alarm_apt, o_startup_done} !== 5'b0) begin
      miss++; $display("FAIL clear: got rd/v/rct/apt/done=%b%b%b%b%b required 00000", obs_read, o_valid, o_alarm_rct, o_alarm_apt, o_startup_done);
    end
    for (int k = 0; k < 32; k++) begin
      dat = (k < 16) ? 8'(8'h40 + k) : 8'(8'h80 + k - 16);
      tick();
      vec++;
      if (obs_vec !== exp_vec) begin miss++; $display("FAIL clear_restart[%0d]: got %h required %h", k, obs_vec, exp_vec); end
      vec++;
      if (o_startup_done !== (k >= 15) || o_valid !== (k >= 16) || (k >= 16 && o_dat !== dat)) begin
        miss++; $display("FAIL clear_fwd[%0d]: got done=%b v=%b dat=%h required done=%b v=%b", k, o_startup_done, o_valid, o_dat, k >= 15, k >= 16);
      end
    end
  endtask

  task automatic test_apt();
    for (int p = 0; p < 11; p++) begin
      dat = (p % 2 == 0) ? 8'h7E : 8'($urandom_range(0, 8'h7D));
      valid = 1;
      tick();
      vec++;
      if (obs_vec !== exp_vec) begin miss++; $display("FAIL apt[%0d]: got %h required %h", p, obs_vec, exp_vec); end
      vec++;
      if (p < 10 && (o_valid !== 1'b1 || o_dat !== dat || o_alarm_apt !== 1'b0)) begin
        miss++; $display("FAIL apt_fwd[%0d]: got v=%b dat=%h apt=%b required 1/%h/0", p, o_valid, o_dat, o_alarm_apt, dat);
      end else if (p == 10 && (o_alarm_apt !== 1'b1 || o_alarm_rct !== 1'b0 || o_valid !== 1'b0)) begin
        miss++; $display("FAIL apt_alarm: got apt=%b rct=%b v=%b required 1/0/0", o_alarm_apt, o_alarm_rct, o_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    valid = 0; clr = 1;
    tick();
    clr = 0; valid = 1;
    for (int k = 0; k < 17; k++) begin
      dat = (k < 16) ? 8'(8'hC0 + k) : 8'h55;
      tick();
    end
    vec++;
    if (o_valid !== 1'b1 || o_dat !== 8'h55) begin miss++; $display("FAIL bp_load: got v=%b dat=%h required 1/55", o_valid, o_dat); end
    ready = 0; dat = 8'h66;
    repeat (5) begin
      tick();
      vec++;
      if (obs_read !== 1'b0 || o_valid !== 1'b1 || o_dat !== 8'h55 || obs_vec !== exp_vec) begin
        miss++; $display("FAIL bp_hold: got rd=%b v=%b dat=%h required 0/1/55", obs_read, o_valid, o_dat);
      end
    end
    ready = 1;
    tick();
    vec++;
    if (obs_read !== 1'b1 || o_valid !== 1'b1 || o_dat !== 8'h66) begin
      miss++; $display("FAIL bp_release: got rd=%b v=%b dat=%h required 1/1/66", obs_read, o_valid, o_dat);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      valid = $urandom_range(0, 3) != 0;
      ready = $urandom_range(0, 3) != 0;
      dat = (c < 200) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      clr = $urandom_range(0, 31) == 0;
      tick();
      vec++;
      if (obs_vec !== exp_vec) begin miss++; $display("FAIL random[%0d]: got %h required %h", c, obs_vec, exp_vec); end
    end
    clr = 0; ready = 1;
  endtask

  task automatic test_reset_mid();
    valid = 0; clr = 1;
    tick();
    clr = 0; valid = 1;
    for (int k = 0; k < 17; k++) begin dat = 8'(8'h20 + k); tick(); end
    vec++;
    if (o_valid !== 1'b1 || o_dat !== 8'h30) begin miss++; $display("FAIL rstmid_pre: got v=%b dat=%h required 1/30", o_valid, o_dat); end
    rst = 1; dat = 8'h99;
    tick();
    rst = 0;
    vec++;
    if ({o_valid, o_alarm_rct, o_alarm_apt, o_startup_done} !== 4'b0 || o_dat !== 8'h00) begin
      miss++; $display("FAIL rstmid: got v/rct/apt/done=%b%b%b%b dat=%h required 0000 dat=00", o_valid, o_alarm_rct, o_alarm_apt, o_startup_done, o_dat);
    end
    for (int k = 0; k < 16; k++) begin
      dat = 8'(k) ^ 8'h5A;
      tick();
      vec++;
      if (obs_vec !== exp_vec || o_startup_done !== (k == 15) || o_valid !== 1'b0) begin
        miss++; $display("FAIL rstmid_startup[%0d]: got %h required %h done=%b", k, obs_vec, exp_vec, k == 15);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_rct();
    test_clear();
    test_apt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
